// File: rtl/booth_r8_pkg.sv
// Shared types and helpers for the sequential radix-8 Booth multiplier.
package booth_r8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRECOMP = 2'd1,
        ST_ITER    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Magnitude codes for one Booth digit (0..4 times X)
    localparam logic [2:0] MAG_ZERO = 3'd0;
    localparam logic [2:0] MAG_X    = 3'd1;
    localparam logic [2:0] MAG_2X   = 3'd2;
    localparam logic [2:0] MAG_3X   = 3'd3;
    localparam logic [2:0] MAG_4X   = 3'd4;

    typedef struct packed {
        logic       neg;
        logic [2:0] mag;
    } digit_t;

    // Number of radix-8 digits needed for an n-bit multiplier, i.e. ceil((n+1)/3)
    function automatic int num_digits(input int n);
        return (n + 3) / 3;
    endfunction

    // Decode a 4-bit overlapping window into sign and magnitude.
    // Negative windows mirror positive ones under bitwise complement of the low 3 bits.
    function automatic digit_t booth_decode(input logic [3:0] w);
        digit_t     d;
        logic [2:0] t;
        t     = w[3] ? ~w[2:0] : w[2:0];
        d.neg = w[3] & ~(&w[2:0]);
        case (t)
            3'b000:         d.mag = MAG_ZERO;
            3'b001, 3'b010: d.mag = MAG_X;
            3'b011, 3'b100: d.mag = MAG_2X;
            3'b101, 3'b110: d.mag = MAG_3X;
            default:        d.mag = MAG_4X;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r8_pp_sel.sv
// Combinational partial-product selector: picks 0/X/2X/3X/4X and negates if needed.
module booth_r8_pp_sel
    import booth_r8_pkg::*;
#(
    parameter int M = 8
) (
    input  logic [3:0]   window,
    input  logic [M+2:0] x_ext,
    input  logic [M+2:0] x3,
    output logic [M+2:0] pp
);

    digit_t       dig;
    logic [M+2:0] mag_val;

    // Magnitude select followed by conditional two's-complement negate
    always_comb begin
        dig = booth_decode(window);
        case (dig.mag)
            MAG_X:   mag_val = x_ext;
            MAG_2X:  mag_val = x_ext << 1;
            MAG_3X:  mag_val = x3;
            MAG_4X:  mag_val = x_ext << 2;
            default: mag_val = '0;
        endcase
        pp = dig.neg ? -mag_val : mag_val;
    end

endmodule

// File: rtl/booth_r8_seq_mult.sv
// Sequential radix-8 Booth multiplier, one digit per clock, signed/unsigned at runtime.
module booth_r8_seq_mult
    import booth_r8_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tc,
    input  logic [M-1:0]     x,
    input  logic [N-1:0]     y,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [M+N-1:0]   product
);

    localparam int G     = num_digits(N);
    localparam int YW    = 3 * G + 1;
    localparam int XW    = M + 3;
    localparam int ACC_W = M + N + 4;
    localparam int IDX_W = (G > 1) ? $clog2(G) : 1;

    state_t             state_reg;
    logic [XW-1:0]      x_ext_reg;
    logic [XW-1:0]      x3_reg;
    logic [YW-1:0]      y_ext_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [M+N-1:0]     product_reg;
    logic               done_reg;
    logic               ready_reg;
    logic               busy_reg;

    logic [XW-1:0]      x_ext_next;
    logic [YW-1:0]      y_ext_next;
    logic [XW-1:0]      pp;
    logic [ACC_W-1:0]   pp_sext;
    logic [ACC_W-1:0]   pp_shift [G];
    logic [ACC_W-1:0]   acc_next;

    // Operand extension applied at capture time; tc only matters here
    assign x_ext_next = {{3{tc & x[M-1]}}, x};
    assign y_ext_next = {{(YW - N - 1){tc & y[N-1]}}, y, 1'b0};

    // y_ext_reg shifts right by 3 each iteration, so the current window is always the low nibble
    booth_r8_pp_sel #(.M(M)) u_pp_sel (
        .window (y_ext_reg[3:0]),
        .x_ext  (x_ext_reg),
        .x3     (x3_reg),
        .pp     (pp)
    );

    assign pp_sext = {{(N + 1){pp[XW-1]}}, pp};

    // Pre-shifted copies of the partial product, one per digit position
    for (genvar gi = 0; gi < G; gi++) begin : g_shift
        assign pp_shift[gi] = pp_sext << (3 * gi);
    end

    assign acc_next = acc_reg + pp_shift[idx_reg];

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            x_ext_reg   <= '0;
            x3_reg      <= '0;
            y_ext_reg   <= '0;
            acc_reg     <= '0;
            idx_reg     <= '0;
            product_reg <= '0;
            done_reg    <= 1'b0;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_ext_reg <= x_ext_next;
                        y_ext_reg <= y_ext_next;
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_PRECOMP;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_PRECOMP: begin
                    x3_reg    <= x_ext_reg + (x_ext_reg << 1);
                    idx_reg   <= '0;
                    state_reg <= ST_ITER;
                end
                ST_ITER: begin
                    acc_reg   <= acc_next;
                    y_ext_reg <= y_ext_reg >> 3;
                    if (idx_reg == IDX_W'(G - 1)) begin
                        product_reg <= acc_next[M+N-1:0];
                        done_reg    <= 1'b1;
                        ready_reg   <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ready   = ready_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// Self-checking bench for booth_r8_seq_mult (M=N=8, done five cycles after accept).
module tb_booth_r8_seq_mult;

    localparam int M   = 8;
    localparam int N   = 8;
    localparam int LAT = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           tc;
    logic [M-1:0]   x;
    logic [N-1:0]   y;
    logic           ready;
    logic           busy;
    logic           done;
    logic [M+N-1:0] product;

    int vectors    = 0;
    int miscompares = 0;
    int cov [9];

    logic [M+N-1:0] got;
    int             lat;
    bit             hs_ok;

    booth_r8_seq_mult #(.M(M), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tc      (tc),
        .x       (x),
        .y       (y),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer multiply of the operands interpreted per tc
    function automatic logic [M+N-1:0] ref_mul(input logic tcv, input logic [M-1:0] a,
                                               input logic [N-1:0] b);
        longint sa, sb;
        sa = tcv ? longint'($signed(a)) : longint'(a);
        sb = tcv ? longint'($signed(b)) : longint'(b);
        return (M+N)'(sa * sb);
    endfunction

    // Record which Booth digit values the multiplier operand exercises
    task automatic note_digits(input logic tcv, input logic [N-1:0] b);
        longint yv;
        int     w, d;
        yv = tcv ? longint'($signed(b)) : longint'(b);
        yv = yv * 2;
        for (int i = 0; i < 3; i++) begin
            w = int'((yv >>> (3 * i)) & 64'd15);
            d = -4 * ((w >> 3) & 1) + 2 * ((w >> 2) & 1) + ((w >> 1) & 1) + (w & 1);
            cov[d + 4]++;
        end
    endtask

    // Issue one operation in the current cycle and wait (bounded) for done.
    // Returns latency in cycles and whether ready/busy stayed low/high while in flight.
    task automatic run_op(input logic tcv, input logic [M-1:0] a, input logic [N-1:0] b,
                          output logic [M+N-1:0] res, output int l, output bit hs);
        tc = tcv; x = a; y = b; start = 1'b1;
        step();
        start = 1'b0;
        x = M'($urandom); y = N'($urandom); tc = 1'($urandom);
        l  = 1;
        hs = 1'b1;
        while (done !== 1'b1 && l < 20) begin
            if (ready !== 1'b0 || busy !== 1'b1) hs = 1'b0;
            step();
            l++;
        end
        res = product;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tc = 1'b0; x = '0; y = '0;
        step(); step();
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            miscompares++;
            $display("FAIL reset: ready=%b busy=%b done=%b product=%h, required 1 0 0 0000",
                     ready, busy, done, product);
        end
        rst = 1'b0;
        step();
        $display("reset: ready=%b busy=%b done=%b product=%h", ready, busy, done, product);
    endtask

    task automatic test_directed();
        logic [M+N-1:0] exp_tab [4] = '{16'h4000, 16'hFE01, 16'hFFEB, 16'hFF81};
        logic           tc_tab  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [M-1:0]   x_tab   [4] = '{8'h80, 8'hFF, 8'h07, 8'hFF};
        logic [N-1:0]   y_tab   [4] = '{8'h80, 8'hFF, 8'hFD, 8'h7F};
        for (int i = 0; i < 4; i++) begin
            run_op(tc_tab[i], x_tab[i], y_tab[i], got, lat, hs_ok);
            $display("directed %0d: tc=%b x=%h y=%h product=%h latency=%0d",
                     i, tc_tab[i], x_tab[i], y_tab[i], got, lat);
            vectors++;
            if (got !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL directed_%0d product: got %h required %h", i, got, exp_tab[i]);
            end
            vectors++;
            if (lat !== LAT || !hs_ok) begin
                miscompares++;
                $display("FAIL directed_%0d timing: latency %0d handshake_ok %0b required %0d 1",
                         i, lat, hs_ok, LAT);
            end
            step();
            vectors++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                miscompares++;
                $display("FAIL directed_%0d done_pulse: done=%b ready=%b required 0 1",
                         i, done, ready);
            end
        end
    endtask

    task automatic test_ignore_start();
        int extra_done = 0;
        tc = 1'b0; x = 8'd2; y = 8'd3; start = 1'b1;
        step();                      // cycle k+1
        start = 1'b0;
        step();                      // cycle k+2
        x = 8'd9; y = 8'd9; start = 1'b1;
        step();                      // cycle k+3
        start = 1'b0;
        step(); step();              // cycle k+5
        $display("ignore_start: done=%b product=%h", done, product);
        vectors++;
        if (done !== 1'b1 || product !== 16'd6) begin
            miscompares++;
            $display("FAIL ignore_start: done=%b product=%h required 1 0006", done, product);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) extra_done++;
        end
        vectors++;
        if (extra_done !== 0) begin
            miscompares++;
            $display("FAIL ignore_start_extra_done: %0d pulses required 0", extra_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [M+N-1:0] exp_v;
        run_op(1'b0, 8'd13, 8'd11, got, lat, hs_ok);
        $display("back_to_back first: product=%h latency=%0d", got, lat);
        vectors++;
        if (got !== 16'd143 || lat !== LAT) begin
            miscompares++;
            $display("FAIL b2b_first: product %h latency %0d required 008f %0d", got, lat, LAT);
        end
        // Still in the DONE cycle: the next start is accepted directly from DONE
        exp_v = ref_mul(1'b1, 8'hF3, 8'h2A);
        run_op(1'b1, 8'hF3, 8'h2A, got, lat, hs_ok);
        $display("back_to_back second: product=%h latency=%0d", got, lat);
        vectors++;
        if (got !== exp_v || lat !== LAT || !hs_ok) begin
            miscompares++;
            $display("FAIL b2b_second: product %h latency %0d hs %0b required %h %0d 1",
                     got, lat, hs_ok, exp_v, LAT);
        end
        step();
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        tc = 1'b0; x = 8'd100; y = 8'd200; start = 1'b1;
        step();                      // k+1
        start = 1'b0;
        step(); step();              // k+3
        rst = 1'b1;
        step();                      // k+4
        rst = 1'b0;
        $display("mid_reset: ready=%b busy=%b done=%b product=%h", ready, busy, done, product);
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_state: ready=%b busy=%b done=%b product=%h required 1 0 0 0000",
                     ready, busy, done, product);
        end
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) pulses++;
            step();
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL mid_reset_done: %0d pulses required 0", pulses);
        end
        run_op(1'b0, 8'd100, 8'd200, got, lat, hs_ok);
        $display("mid_reset restart: product=%h latency=%0d", got, lat);
        vectors++;
        if (got !== 16'd20000 || lat !== LAT) begin
            miscompares++;
            $display("FAIL mid_reset_restart: product %h latency %0d required 4e20 %0d",
                     got, lat, LAT);
        end
        step();
    endtask

    task automatic test_random();
        logic           tcv;
        logic [M-1:0]   a;
        logic [N-1:0]   b;
        logic [M+N-1:0] exp_v;
        int             missing = 0;
        for (int i = 0; i < 10000; i++) begin
            tcv = 1'($urandom);
            a   = M'($urandom);
            b   = N'($urandom);
            if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 1) ? 8'h80 : 8'hFF;
            if ($urandom_range(0, 15) == 0) b = $urandom_range(0, 1) ? 8'h80 : 8'h7F;
            exp_v = ref_mul(tcv, a, b);
            note_digits(tcv, b);
            run_op(tcv, a, b, got, lat, hs_ok);
            $display("rand %0d: tc=%b x=%h y=%h product=%h expected=%h", i, tcv, a, b, got, exp_v);
            vectors++;
            if (got !== exp_v || lat !== LAT || !hs_ok) begin
                miscompares++;
                $display("FAIL rand_%0d: tc=%b x=%h y=%h product %h latency %0d hs %0b required %h %0d 1",
                         i, tcv, a, b, got, lat, hs_ok, exp_v, LAT);
            end
        end
        for (int d = 0; d < 9; d++) if (cov[d] == 0) missing++;
        vectors++;
        if (missing !== 0) begin
            miscompares++;
            $display("FAIL digit_coverage: %0d digit values unhit required 0", missing);
        end
        step();
    endtask

    initial begin
        for (int d = 0; d < 9; d++) cov[d] = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/booth_r8_seq_mult.md
Name: booth_r8_seq_mult

Overview:
- Sequential, parametrised radix-8 Booth multiplier (X width M, Y width N), one Booth digit per clock.
- Precomputes 3X once per operation, then accumulates G partial products, each shifted by 3*i.
- Runtime select between signed (two's complement) and unsigned operands.
- Successor to the combinational radix-8 digit selector; sits in the multiplier datapath behind a start/ready/done handshake.

Parameters:
- M, 8, multiplicand (x) width in bits, >= 3
- N, 8, multiplier (y) width in bits, >= 3
- G (localparam), ceil((N+1)/3), Booth digit count; also the iteration count in both modes

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- tc  in  1  1 = operands signed (two's complement), 0 = unsigned; captured on accept
- x  in  M  multiplicand; captured on accept
- y  in  N  multiplier; captured on accept
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in PRECOMP and ITER
- done  out  1  one-cycle pulse; product valid
- product  out  M+N  result; held until next accept or reset

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, product=0, done=0, busy=0, ready=1, all internal registers cleared. Applies from any state. An operation in flight is abandoned and no done pulse is produced.
- Operand extension:
  - X is extended to M+3 bits: sign-extended when tc=1, zero-extended when tc=0.
  - Y is extended to 3G+1 bits as {ext, y, 1'b0}: the top bits are sign-extended when tc=1 and zero-filled when tc=0; the appended LSB is 0.
- Digit i (i = 0..G-1) uses the window w = Yext[3i+3 : 3i], 4 bits.
  - Digit value d = -4*w[3] + 2*w[2] + w[1] + w[0].
  - 0000 and 1111 give 0; 0001 and 0010 give +1; 0011 and 0100 give +2; 0101 and 0110 give +3; 0111 gives +4.
  - 1000 gives -4; 1001 and 1010 give -3; 1011 and 1100 give -2; 1101 and 1110 give -1.
- Partial product pp = d * Xext, M+3 bits signed. The ±3 cases use the registered 3X (X3 = X + 2X, M+3 bits); no multiplier is inferred.
- Accumulator: acc is M+N+4 bits signed, acc <= acc + (sext(pp) << 3i). Final product = acc[M+N-1:0], exact in both modes.
- FSM states: IDLE, PRECOMP, ITER, DONE.
  - IDLE: if start, capture x, y and tc, clear acc, go to PRECOMP; otherwise stay.
  - PRECOMP: compute X3 (1 cycle), set i=0, go to ITER.
  - ITER: add digit i; if i==G-1 go to DONE, else i++.
  - DONE: product<=acc slice, done=1 for this cycle only. If start, accept new operands (as IDLE) and go to PRECOMP; otherwise go to IDLE.
- Latency: start accepted at edge k -> done high in cycle k+G+2. Fixed, independent of operand values. Throughput is one result per G+2 cycles when back-to-back.
- start while busy is ignored; the in-flight operands are unaffected.
- Signed mode: the extra top digit is always 0, which gives identical latency in both modes.
- No overflow is possible: M+N bits hold every signed or unsigned product.

Decomposition:
- Package booth_r8_pkg:
  - state enum (IDLE, PRECOMP, ITER, DONE)
  - function num_digits(N) = (N+3)/3
  - digit encoding constants (magnitude 0..4, negate flag)
- Sub-module booth_r8_pp_sel (combinational):
  - inputs: 4-bit window, Xext, X3
  - output: M+3-bit signed pp
  - implementation: magnitude select (0, X, 2X, X3, 4X) followed by conditional two's-complement negate

Test Plan (M=N=8, G=3, done at k+5):
1. tc=1, x=-128, y=-128, start at k -> done=1 only in cycle k+5, product=16'h4000; ready=0 during k+1..k+4.
2. tc=0, x=255, y=255 -> product=16'hFE01 (65025). Same latency as scenario 1.
3. tc=1, x=7, y=-3 -> product=16'hFFEB (-21). Exercises digit -3 through the X3 path. Then tc=1, x=-1, y=127 -> 16'hFF81.
4. Start x=2, y=3 (product 6), then pulse start with x=9, y=9 at k+2 -> the second start is ignored; product=6 at k+5. Repeat with start held high in the DONE cycle -> the second operation is accepted and its done arrives 5 cycles later.
5. rst=1 at k+3 mid-ITER -> next cycle state IDLE, product=0, done never pulses, ready=1. A new start then completes normally.
6. Random sweep of 10k operand pairs over both tc values, compared against a reference multiply -> zero mismatches, with every digit value -4..+4 hit in coverage.
